// File: rtl/id_ex_fwd_pkg.sv
// Shared encodings for the ID/EX register, forwarding and ALU.
// Imported by the ID/EX stage, its comparator and the ALU.
package id_ex_fwd_pkg;

  typedef logic [1:0] fwd_t;

  localparam fwd_t FWD_RF  = 2'b00;
  localparam fwd_t FWD_Y   = 2'b01;
  localparam fwd_t FWD_MD  = 2'b10;
  localparam fwd_t FWD_MDN = 2'b11;

  localparam logic [1:0] ASRC2_REG  = 2'd0;
  localparam logic [1:0] ASRC2_PC   = 2'd1;
  localparam logic [1:0] ASRC2_ZERO = 2'd2;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SLL = 3'd1;
  localparam logic [2:0] ALU_SLT = 3'd2;
  localparam logic [2:0] ALU_XOR = 3'd3;
  localparam logic [2:0] ALU_SR  = 3'd4;
  localparam logic [2:0] ALU_OR  = 3'd5;
  localparam logic [2:0] ALU_AND = 3'd6;
  localparam logic [2:0] ALU_LUI = 3'd7;

endpackage

// File: rtl/id_ex_fwd_if.sv
// Decode-side bundle into the ID/EX register: instruction fields,
// flush in, load-use stall out. master = decode, slave = ID/EX.
interface id_ex_fwd_if #(
  parameter int XLEN  = 32,
  parameter int RADDR = 5
);
  logic             id_valid;
  logic [XLEN-1:0]  id_pc;
  logic [RADDR-1:0] id_rs1;
  logic [RADDR-1:0] id_rs2;
  logic [RADDR-1:0] id_rd;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [XLEN-1:0]  id_a0;
  logic [XLEN-1:0]  id_b0;
  logic [XLEN-1:0]  id_imm;
  logic             id_alusrc1;
  logic [1:0]       id_alusrc2;
  logic [2:0]       id_aluop;
  logic             id_sp_sign;
  logic             id_uors;
  logic             id_reg_write;
  logic             id_mem_read;
  logic             flush;
  logic             stall;

  modport master (
    output id_valid, id_pc, id_rs1, id_rs2, id_rd,
    output id_use_rs1, id_use_rs2, id_a0, id_b0, id_imm,
    output id_alusrc1, id_alusrc2, id_aluop,
    output id_sp_sign, id_uors, id_reg_write, id_mem_read,
    output flush,
    input  stall
  );

  modport slave (
    input  id_valid, id_pc, id_rs1, id_rs2, id_rd,
    input  id_use_rs1, id_use_rs2, id_a0, id_b0, id_imm,
    input  id_alusrc1, id_alusrc2, id_aluop,
    input  id_sp_sign, id_uors, id_reg_write, id_mem_read,
    input  flush,
    output stall
  );
endinterface

// File: rtl/id_ex_fwd_fwd_sel.sv
// Forwarding select for one source against the EX/MEM/WB tags.
// In: rs index, use flag, three (rd, wr) tags. Out: 2-bit select.
module fwd_sel
  import id_ex_fwd_pkg::*;
#(
  parameter int RADDR = 5
) (
  input  logic [RADDR-1:0] rs_i,
  input  logic             use_i,
  input  logic [RADDR-1:0] ex_rd_i,
  input  logic             ex_wr_i,
  input  logic [RADDR-1:0] mem_rd_i,
  input  logic             mem_wr_i,
  input  logic [RADDR-1:0] wb_rd_i,
  input  logic             wb_wr_i,
  output fwd_t             sel_o
);

  // Youngest producer wins, so test EX first.
  always_comb begin
    sel_o = FWD_RF;
    if (use_i && rs_i != '0) begin
      if (ex_wr_i && ex_rd_i == rs_i)
        sel_o = FWD_Y;
      else if (mem_wr_i && mem_rd_i == rs_i)
        sel_o = FWD_MD;
      else if (wb_wr_i && wb_rd_i == rs_i)
        sel_o = FWD_MDN;
    end
  end

endmodule

// File: rtl/id_ex_fwd.sv
// ID/EX pipeline register with forwarding selects and load-use stall.
// Ports: clk, rstn, id (slave bundle), EX-side ALU/control outputs.
module id_ex_fwd
  import id_ex_fwd_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int RADDR = 5
) (
  input  logic             clk,
  input  logic             rstn,
  id_ex_fwd_if.slave       id,
  output logic             ex_valid,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  a0,
  output logic [XLEN-1:0]  b0,
  output logic [XLEN-1:0]  imm,
  output logic             ALUSrc1,
  output logic [1:0]       ALUSrc2,
  output logic [2:0]       ALUOP,
  output logic             sp_sign,
  output logic             uors,
  output fwd_t             afwd,
  output fwd_t             bfwd,
  output logic [RADDR-1:0] ex_rd,
  output logic             ex_reg_write,
  output logic             ex_mem_read
);

  typedef struct packed {
    logic             valid;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  a0;
    logic [XLEN-1:0]  b0;
    logic [XLEN-1:0]  imm;
    logic             alusrc1;
    logic [1:0]       alusrc2;
    logic [2:0]       aluop;
    logic             sp_sign;
    logic             uors;
    fwd_t             afwd;
    fwd_t             bfwd;
    logic [RADDR-1:0] rd;
    logic             wr;
    logic             ld;
  } ex_t;

  ex_t              ex_d, ex_q;
  logic [RADDR-1:0] mem_rd_q, wb_rd_q;
  logic             mem_wr_q, wb_wr_q;
  logic             hazard, load;
  fwd_t             afwd_d, bfwd_d;

  // A load in EX cannot forward in time; hold ID for one cycle.
  assign hazard = ex_q.valid & ex_q.ld & (ex_q.rd != '0) &
                  ((id.id_use_rs1 & (id.id_rs1 == ex_q.rd)) |
                   (id.id_use_rs2 & (id.id_rs2 == ex_q.rd)));
  assign id.stall = id.id_valid & ~id.flush & hazard;
  assign load     = id.id_valid & ~id.flush & ~hazard;

  fwd_sel #(.RADDR(RADDR)) u_afwd (
    .rs_i    (id.id_rs1),
    .use_i   (id.id_use_rs1),
    .ex_rd_i (ex_q.rd),
    .ex_wr_i (ex_q.wr),
    .mem_rd_i(mem_rd_q),
    .mem_wr_i(mem_wr_q),
    .wb_rd_i (wb_rd_q),
    .wb_wr_i (wb_wr_q),
    .sel_o   (afwd_d)
  );

  fwd_sel #(.RADDR(RADDR)) u_bfwd (
    .rs_i    (id.id_rs2),
    .use_i   (id.id_use_rs2),
    .ex_rd_i (ex_q.rd),
    .ex_wr_i (ex_q.wr),
    .mem_rd_i(mem_rd_q),
    .mem_wr_i(mem_wr_q),
    .wb_rd_i (wb_rd_q),
    .wb_wr_i (wb_wr_q),
    .sel_o   (bfwd_d)
  );

  always_comb begin
    ex_d = '0;
    if (load) begin
      ex_d.valid   = 1'b1;
      ex_d.pc      = id.id_pc;
      ex_d.a0      = id.id_a0;
      ex_d.b0      = id.id_b0;
      ex_d.imm     = id.id_imm;
      ex_d.alusrc1 = id.id_alusrc1;
      ex_d.alusrc2 = id.id_alusrc2;
      ex_d.aluop   = id.id_aluop;
      ex_d.sp_sign = id.id_sp_sign;
      ex_d.uors    = id.id_uors;
      ex_d.afwd    = afwd_d;
      ex_d.bfwd    = bfwd_d;
      ex_d.rd      = id.id_rd;
      ex_d.wr      = id.id_reg_write;
      ex_d.ld      = id.id_mem_read;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ex_q     <= '0;
      mem_rd_q <= '0;
      mem_wr_q <= 1'b0;
      wb_rd_q  <= '0;
      wb_wr_q  <= 1'b0;
    end else begin
      ex_q     <= ex_d;
      mem_rd_q <= ex_q.rd;
      mem_wr_q <= ex_q.wr;
      wb_rd_q  <= mem_rd_q;
      wb_wr_q  <= mem_wr_q;
    end
  end

  assign ex_valid     = ex_q.valid;
  assign pc           = ex_q.pc;
  assign a0           = ex_q.a0;
  assign b0           = ex_q.b0;
  assign imm          = ex_q.imm;
  assign ALUSrc1      = ex_q.alusrc1;
  assign ALUSrc2      = ex_q.alusrc2;
  assign ALUOP        = ex_q.aluop;
  assign sp_sign      = ex_q.sp_sign;
  assign uors         = ex_q.uors;
  assign afwd         = ex_q.afwd;
  assign bfwd         = ex_q.bfwd;
  assign ex_rd        = ex_q.rd;
  assign ex_reg_write = ex_q.wr;
  assign ex_mem_read  = ex_q.ld;

endmodule
